// File: rtl/fifo_prog.sv
// fifo_prog: first-word-fall-through FIFO of any depth with programmable almost-full/empty
// thresholds, fill level, sticky overflow/underflow flags and synchronous flush.
module fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int LOG2DEPTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_write_enable,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_read_enable,
  output logic                  o_empty,
  input  logic [LOG2DEPTH:0]    i_afull_thresh,
  input  logic [LOG2DEPTH:0]    i_aempty_thresh,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [LOG2DEPTH:0]    o_level,
  input  logic                  i_flush,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clear_err
);
  localparam int LW = LOG2DEPTH + 1;
  localparam logic [LOG2DEPTH-1:0] LAST = LOG2DEPTH'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2DEPTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  deq, enq;
  assign o_empty        = level_q == '0;
  assign o_full         = level_q == FULL_LEVEL;
  assign o_level        = level_q;
  assign o_almost_full  = level_q >= i_afull_thresh;
  assign o_almost_empty = level_q <= i_aempty_thresh;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;
  assign o_data         = o_empty ? '0 : mem_q[rd_ptr_q];
  assign deq            = i_read_enable & !o_empty;
  assign enq            = i_write_enable & (!o_full | deq);
  // Flush drops any same-cycle transfer and suppresses the error flags it would raise.
  always_comb begin
    wr_ptr_d = i_flush ? '0 : !enq ? wr_ptr_q : wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = i_flush ? '0 : !deq ? rd_ptr_q : rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1;
    level_d  = i_flush ? '0 : (enq & !deq) ? level_q + LW'(1) :
               (deq & !enq) ? level_q - LW'(1) : level_q;
    ovf_d    = (i_write_enable & !enq & !i_flush) | (ovf_q & !i_clear_err);
    unf_d    = (i_read_enable & o_empty & !i_flush) | (unf_q & !i_clear_err);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq & !i_flush & !reset) mem_q[wr_ptr_q] <= i_data;
  end
endmodule
